// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_if
//  Description : Requester/grant bundle between the LBIST pattern sources
//                (master side) and the shared bus-register arbiter (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int BUS_WIDTH = 16
);
    logic [N_REQ-1:0]           req;
    logic [N_REQ*BUS_WIDTH-1:0] data_in_all;
    logic [N_REQ-1:0]           gnt;
    logic                       ld;
    logic [BUS_WIDTH-1:0]       bus_data;
    logic [N_REQ-1:0]           done;
    logic                       busy;
    logic                       timeout_err;

    // Requesters drive requests and data and observe the arbiter's result.
    modport master (
        output req, data_in_all,
        input  gnt, ld, bus_data, done, busy, timeout_err
    );

    // The arbiter consumes requests and owns every status output.
    modport slave (
        input  req, data_in_all,
        output gnt, ld, bus_data, done, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin arbiter sharing one bus register between N_REQ
//                requesters. IDLE -> LOAD (one LD strobe) -> HOLD until the
//                winner drops its request. Optional HOLD timeout is enabled
//                with the macro BUS_ARB_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int BUS_WIDTH = 16,
    parameter int HOLD_MAX  = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    bus_arbiter_if.slave bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_hold = 2'd2;

    // Reject parameter sets the pointer/counter logic was not sized for.
    if (N_REQ < 2 || N_REQ > 8 || HOLD_MAX < 1) begin : g_param_check
        $error("bus_arbiter: N_REQ must be 2..8 and HOLD_MAX >= 1");
    end

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_win;
    logic [PTR_W-1:0]     w_win;
    logic                 w_found;
    logic                 w_any_req;
    logic                 w_release;
    logic                 w_timeout;
    logic                 w_timeout_err;
    logic [BUS_WIDTH-1:0] r_bus_data;
    logic [N_REQ-1:0]     r_done;

    assign w_any_req = |bus.req;
    // Normal release has priority over a timeout in the same cycle.
    assign w_release = (r_state == c_hold) && !bus.req[r_win];

    // Round-robin search: first request at or after r_ptr+1, wrapping.
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && bus.req[(int'(r_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = PTR_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout_err;

    // Fires on the HOLD_MAX-th HOLD cycle while the winner still requests.
    assign w_timeout = (r_state == c_hold) && bus.req[r_win] &&
                       (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
    assign w_timeout_err = r_timeout_err;

    // Count HOLD cycles; cleared on the way into HOLD; sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == c_load) begin
                r_hold_cnt <= '0;
            end else if (r_state == c_hold) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            if (w_timeout && !w_release) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout     = 1'b0;
    assign w_timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_any_req) w_state_nxt = c_load;
            c_load:  w_state_nxt = c_hold;
            c_hold:  if (w_release || w_timeout) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Winner capture, bus data load, release pulse and pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= PTR_W'(N_REQ - 1);
            r_win      <= '0;
            r_bus_data <= '0;
            r_done     <= '0;
        end else begin
            r_done <= '0;
            if (r_state == c_idle && w_any_req) begin
                r_win      <= w_win;
                r_bus_data <= bus.data_in_all[w_win*BUS_WIDTH +: BUS_WIDTH];
            end
            if (w_release) begin
                r_done <= N_REQ'(1) << r_win;
                r_ptr  <= r_win;
            end else if (w_timeout) begin
                r_ptr  <= r_win;
            end
        end
    end

    // Outputs decoded from registered state only, so they are glitch-free.
    always_comb begin
        bus.gnt         = (r_state != c_idle) ? (N_REQ'(1) << r_win) : '0;
        bus.ld          = (r_state == c_load);
        bus.busy        = (r_state != c_idle);
        bus.bus_data    = r_bus_data;
        bus.done        = r_done;
        bus.timeout_err = w_timeout_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed self-checking bench for bus_arbiter (N_REQ=4,
//                BUS_WIDTH=16, HOLD_MAX=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.N_REQ(4), .BUS_WIDTH(16)) bus ();

    bus_arbiter #(.N_REQ(4), .BUS_WIDTH(16), .HOLD_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] slice(input int i);
        case (i)
            0: return 16'hFFFD;
            1: return 16'h1111;
            2: return 16'h2222;
            default: return 16'hBDC7;
        endcase
    endfunction

    initial begin
        bus.req         = 4'b0000;
        bus.data_in_all = {16'hBDC7, 16'h2222, 16'h1111, 16'hFFFD};
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt",  32'(bus.gnt), 32'h0);
        check("rst_ld",   32'(bus.ld), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_data", 32'(bus.bus_data), 32'h0);
        check("rst_terr", 32'(bus.timeout_err), 32'h0);
        rst = 1'b0;

        // Single requester: grant, LD pulse, release.
        bus.req = 4'b0001;
        tick();
        check("t1_gnt",  32'(bus.gnt), 32'h1);
        check("t1_ld",   32'(bus.ld), 32'h1);
        check("t1_data", 32'(bus.bus_data), 32'hFFFD);
        check("t1_busy", 32'(bus.busy), 32'h1);
        tick();
        check("t1_ld_off", 32'(bus.ld), 32'h0);
        check("t1_hold",   32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("t1_rel_gnt",  32'(bus.gnt), 32'h0);
        check("t1_done",     32'(bus.done), 32'h1);
        check("t1_rel_busy", 32'(bus.busy), 32'h0);
        tick();
        check("t1_done_off", 32'(bus.done), 32'h0);

        // All request, each releases in first HOLD cycle: order 0,1,2,3,0.
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int w;
            w = i % 4;
            tick();
            check("t2_gnt",  32'(bus.gnt), 32'(4'b0001 << w));
            check("t2_ld",   32'(bus.ld), 32'h1);
            check("t2_data", 32'(bus.bus_data), 32'(slice(w)));
            tick();
            check("t2_ld_off", 32'(bus.ld), 32'h0);
            bus.req[w] = 1'b0;
            tick();
            check("t2_idle_gnt", 32'(bus.gnt), 32'h0);
            check("t2_done",     32'(bus.done), 32'(4'b0001 << w));
            bus.req[w] = 1'b1;
        end
        bus.req = 4'b0000;
        tick();

        // PTR=1 with REQ=1001 picks requester 3.
        do_reset();
        bus.req = 4'b0010;
        tick();
        check("t3_pre_gnt", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0000;
        tick();
        tick();
        check("t3_pre_done", 32'(bus.done), 32'h2);
        bus.req = 4'b1001;
        tick();
        check("t3_gnt",  32'(bus.gnt), 32'h8);
        check("t3_data", 32'(bus.bus_data), 32'hBDC7);
        bus.req = 4'b0000;
        tick();
        tick();
        check("t3_done", 32'(bus.done), 32'h8);

        // Async reset during HOLD of requester 2.
        do_reset();
        bus.req = 4'b0100;
        tick();
        check("t4_gnt", 32'(bus.gnt), 32'h4);
        tick();
        check("t4_hold", 32'(bus.gnt), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check("t4_async_gnt",  32'(bus.gnt), 32'h0);
        check("t4_async_ld",   32'(bus.ld), 32'h0);
        check("t4_async_busy", 32'(bus.busy), 32'h0);
        check("t4_async_done", 32'(bus.done), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req = 4'b0101;
        check("t4_nodone", 32'(bus.done), 32'h0);
        tick();
        check("t4_restart", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        tick();
        tick();
        tick();

        // Winner drops REQ during LOAD.
        do_reset();
        bus.req = 4'b0001;
        tick();
        check("t6_ld", 32'(bus.ld), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("t6_ld_off",  32'(bus.ld), 32'h0);
        check("t6_gnt",     32'(bus.gnt), 32'h1);
        check("t6_no_done", 32'(bus.done), 32'h0);
        tick();
        check("t6_done",    32'(bus.done), 32'h1);
        check("t6_rel_gnt", 32'(bus.gnt), 32'h0);
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        // REQ0 stuck: forced release after 8 HOLD cycles, then REQ1.
        do_reset();
        bus.req = 4'b0011;
        tick();
        check("t5_gnt", 32'(bus.gnt), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_hold", 32'(bus.gnt), 32'h1);
            check("t5_done", 32'(bus.done), 32'h0);
        end
        tick();
        check("t5_drop", 32'(bus.gnt), 32'h0);
        check("t5_terr", 32'(bus.timeout_err), 32'h1);
        check("t5_nodone", 32'(bus.done), 32'h0);
        tick();
        check("t5_next", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0000;
        tick();
        tick();
        tick();
        check("t5_sticky", 32'(bus.timeout_err), 32'h1);
`else
        // Without the timeout option a stuck requester holds indefinitely.
        do_reset();
        bus.req = 4'b0001;
        repeat (20) tick();
        check("t5_hold_forever", 32'(bus.gnt), 32'h1);
        check("t5_terr_zero",    32'(bus.timeout_err), 32'h0);
        bus.req = 4'b0000;
        tick();
        check("t5_late_done", 32'(bus.done), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
